keypad_scan_ctrl: RTL and testbench
===================================

Name: keypad_scan_ctrl

Overview:
Autonomous 4x4 matrix-keypad scanner with an Avalon-MM slave register interface for the Nios II. Drives column lines one at a time, samples row lines, debounces whole-matrix frames, and pushes 4-bit key codes for new presses into a small FIFO. It replaces software polling of the raw keypad row input port and raises an IRQ while codes are pending.

Parameters:
SCAN_DIV, 50000, clk cycles each column is driven; must be >= 4 (50000 = 1 ms at 50 MHz).
DEBOUNCE_SCANS, 4, consecutive identical frames required before a frame is accepted; range 2..15.
FIFO_DEPTH, 4, key-code FIFO entries; power of 2, range 2..16.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select: 0 DATA, 1 STATUS, 2 CONTROL, 3 CLEAR
chipselect  in  1  slave select
read  in  1  read strobe, qualified by chipselect
write  in  1  write strobe, qualified by chipselect
writedata  in  32  write data
readdata  out  32  registered read data, latency 1
irq  out  1  level interrupt
col_n  out  4  column drive, active-low one-hot; 4'hF = idle
row_n  in  4  raw row inputs, active-low with pull-ups, asynchronous

Behaviour:
- Reset: clk and reset_n as already decided. reset_n asynchronous, active-low. Outputs on reset: readdata=0, irq=0, col_n=4'hF. Internal state on reset: FIFO empty, CONTROL=0, overflow=0, debounce state cleared, FSM in IDLE.
- row_n passes through a 2-FF synchronizer. pressed bit = ~row_n_sync.
- Scan FSM states:
  - IDLE: col_n=4'hF. Move to COL when CONTROL.enable=1.
  - COL(k), k=0..3: col_n = ~(1<<k) for SCAN_DIV cycles. On the last cycle of the slot, latch pressed[3:0] into frame[4k+3:4k]. After k=3, go to EVAL.
  - EVAL: one cycle. Then COL(0).
  - One frame = 4*SCAN_DIV+1 cycles.
  - enable=0 in any state: next cycle goes to IDLE, col_n=4'hF. Frame, stable count and reported are cleared. FIFO contents and overflow are kept.
- Debounce, evaluated in EVAL:
  - If frame == prev_frame, stable_cnt saturates-increments; otherwise stable_cnt=0.
  - prev_frame <= frame.
  - The frame is accepted when stable_cnt reaches DEBOUNCE_SCANS-1, i.e. DEBOUNCE_SCANS identical frames. Acceptance repeats every EVAL while the frame stays stable.
- On acceptance:
  - Released keys are cleared: reported &= frame.
  - newly = frame & ~reported. If newly != 0, take the lowest set index i, push code i (i = 4*col+row, 4 bits) and set reported[i].
  - At most one push per EVAL. Further simultaneous presses are pushed on later EVALs.
- FIFO push takes effect on the cycle after EVAL.
  - Push when full without a same-cycle pop: code dropped, overflow=1.
  - Push and pop in the same cycle: both happen. When full, the push is accepted and count is unchanged.
- Registers (read data appears the cycle after the read strobe):
  - 0 DATA, read: {27'b0, valid, code[3:0]}. When not empty, valid=1, returns the head entry and pops. When empty, returns 0 and does not pop. Writes are ignored.
  - 1 STATUS, read-only: [0] not_empty, [1] full, [2] overflow, [3] key_down (|reported), [7:4] count.
  - 2 CONTROL, R/W: [0] enable, [1] irq_en. Other bits read 0.
  - 3 CLEAR, write: writedata[0]=1 clears overflow; writedata[1]=1 flushes the FIFO. Reads return 0.
  - Flush and push in the same cycle: the flush wins.
- irq = irq_en & not_empty, registered (1 cycle after the FIFO state changes).
- readdata holds its last value when there is no read.

Decomposition:
- Shared package keypad_pkg holds:
  - register address constants (ADDR_DATA/STATUS/CONTROL/CLEAR)
  - STATUS and CONTROL bit-index constants
  - scan state enum (IDLE, COL, EVAL)
  - keycode width (4)
- One sub-module, keypad_code_fifo: synchronous FIFO with push, pop, flush, full, empty, count and overflow sticky. The scan FSM, debounce logic and register file stay in the top level.

Test Plan:
1. Reset: assert reset_n=0 mid-scan -> col_n=4'hF, readdata=0, irq=0, STATUS=0.
2. Basic press. Setup: SCAN_DIV=4, DEBOUNCE_SCANS=3, CONTROL=3; model holds row 2 low whenever col 1 is driven.
   -> Exactly one code 6 is pushed after the 3rd identical frame EVAL, and irq rises.
   -> DATA read returns 0x16; irq falls; a second DATA read returns 0.
3. Bounce: toggle key 6 every other frame for 5 frames, then hold -> no push during toggling; one push 3 frames after the hold starts.
4. Multi-key: hold keys 0 and 15 together -> code 0 is pushed at the first acceptance, code 15 at the next EVAL; STATUS[3]=1; after release, STATUS[3]=0.
5. Overflow: 5 distinct press/release sequences with no reads and FIFO_DEPTH=4 -> STATUS full=1, overflow=1, count=4; the first DATA read returns the first code. Write CLEAR=1 -> overflow=0.
6. Disable mid-frame in COL(2): write CONTROL=0 -> col_n=4'hF next cycle, FIFO count unchanged. Re-enable -> scanning restarts at COL(0) with the debounce count at 0.

Source files
------------

// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared constants and types for the keypad scanner: register map, bit positions,
// scan state encoding and key-code width.
package keypad_pkg;

    localparam int KEY_W = 4;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_CLEAR   = 2'd3;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_KEY_DOWN  = 3;

    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;

    localparam int CLR_OVERFLOW = 0;
    localparam int CLR_FLUSH    = 1;

    typedef enum logic [1:0] {
        SCAN_IDLE = 2'd0,
        SCAN_COL  = 2'd1,
        SCAN_EVAL = 2'd2
    } scan_state_t;

endpackage

// File: rtl/keypad_scan_ctrl_code_fifo.sv
// Small synchronous FIFO of key codes with flush and a sticky overflow flag.
// A flush overrides any push or pop in the same cycle.
module keypad_code_fifo
    import keypad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [KEY_W-1:0] push_code,
    input  logic             pop,
    input  logic             flush,
    input  logic             clr_overflow,
    output logic [KEY_W-1:0] head,
    output logic             empty,
    output logic             full,
    output logic [4:0]       count,
    output logic             overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == 5'd0);
    assign full    = (count == 5'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
                count <= count + {4'b0, do_push} - {4'b0, do_pop};
            end
            if (clr_overflow) overflow <= 1'b0;
            if (push & full & ~do_pop & ~flush) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~flush) mem[wr_ptr] <= push_code;
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive FSM, whole-frame debounce, new-press detection
// feeding a key-code FIFO, and an Avalon-MM register file with level IRQ.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [3:0]  col_n,
    input  logic [3:0]  row_n
);

    localparam int               DIV_W         = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST      = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]       STABLE_ACCEPT = 4'(DEBOUNCE_SCANS - 1);

    scan_state_t      state;
    logic [1:0]       col_idx;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       row_n_p0;
    logic [3:0]       row_n_p1;
    logic [3:0]       pressed;
    logic [15:0]      frame;
    logic [15:0]      prev_frame;
    logic [3:0]       stable_cnt;
    logic [15:0]      reported;
    logic             push_req;
    logic [KEY_W-1:0] push_code;

    logic             ctrl_enable;
    logic             ctrl_irq_en;
    logic             bus_rd;
    logic             bus_wr;
    logic             ctrl_wr;
    logic             clr_wr;
    logic             enable_next;

    logic [3:0]       stable_next;
    logic             accept;
    logic [15:0]      reported_kept;
    logic [15:0]      newly;
    logic [KEY_W-1:0] new_idx;

    logic             fifo_pop;
    logic             fifo_flush;
    logic             fifo_clr_ovf;
    logic [KEY_W-1:0] fifo_head;
    logic             fifo_empty;
    logic             fifo_full;
    logic [4:0]       fifo_count;
    logic             fifo_overflow;
    logic [3:0]       count4;
    logic [31:0]      status_word;
    logic             unused_bits;

    function automatic logic [KEY_W-1:0] lowest_set(input logic [15:0] v);
        lowest_set = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_set = KEY_W'(i);
        end
    endfunction

    // row_n is asynchronous to clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_n_p0 <= 4'hF;
            row_n_p1 <= 4'hF;
        end else begin
            row_n_p0 <= row_n;
            row_n_p1 <= row_n_p0;
        end
    end

    assign pressed = ~row_n_p1;

    assign bus_rd       = chipselect & read;
    assign bus_wr       = chipselect & write;
    assign ctrl_wr      = bus_wr & (address == ADDR_CONTROL);
    assign clr_wr       = bus_wr & (address == ADDR_CLEAR);
    // The scanner reacts to a CONTROL write on the same edge that stores it.
    assign enable_next  = ctrl_wr ? writedata[CTRL_ENABLE] : ctrl_enable;
    assign fifo_pop     = bus_rd & (address == ADDR_DATA) & ~fifo_empty;
    assign fifo_flush   = clr_wr & writedata[CLR_FLUSH];
    assign fifo_clr_ovf = clr_wr & writedata[CLR_OVERFLOW];
    assign unused_bits  = ^writedata[31:2];

    assign stable_next   = (frame != prev_frame) ? 4'd0 :
                           (stable_cnt == 4'hF)  ? 4'hF : stable_cnt + 4'd1;
    assign accept        = (stable_next >= STABLE_ACCEPT);
    assign reported_kept = reported & frame;
    assign newly         = frame & ~reported_kept;
    assign new_idx       = lowest_set(newly);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SCAN_IDLE;
            col_idx    <= 2'd0;
            div_cnt    <= '0;
            col_n      <= 4'hF;
            frame      <= '0;
            prev_frame <= '0;
            stable_cnt <= '0;
            reported   <= '0;
            push_req   <= 1'b0;
            push_code  <= '0;
        end else begin
            push_req <= 1'b0;
            if (!enable_next) begin
                state      <= SCAN_IDLE;
                col_idx    <= 2'd0;
                div_cnt    <= '0;
                col_n      <= 4'hF;
                frame      <= '0;
                prev_frame <= '0;
                stable_cnt <= '0;
                reported   <= '0;
            end else begin
                case (state)
                    SCAN_IDLE: begin
                        state   <= SCAN_COL;
                        col_idx <= 2'd0;
                        div_cnt <= '0;
                        col_n   <= 4'hE;
                    end
                    SCAN_COL: begin
                        if (div_cnt == DIV_LAST) begin
                            frame[{col_idx, 2'b00} +: 4] <= pressed;
                            div_cnt <= '0;
                            if (col_idx == 2'd3) begin
                                state <= SCAN_EVAL;
                                col_n <= 4'hF;
                            end else begin
                                col_idx <= col_idx + 2'd1;
                                col_n   <= ~(4'b0001 << (col_idx + 2'd1));
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    SCAN_EVAL: begin
                        stable_cnt <= stable_next;
                        prev_frame <= frame;
                        state      <= SCAN_COL;
                        col_idx    <= 2'd0;
                        div_cnt    <= '0;
                        col_n      <= 4'hE;
                        // One new key per accepted frame; remaining presses go out on later frames.
                        if (accept) begin
                            if (|newly) begin
                                push_req  <= 1'b1;
                                push_code <= new_idx;
                                reported  <= reported_kept | (16'b1 << new_idx);
                            end else begin
                                reported  <= reported_kept;
                            end
                        end
                    end
                    default: state <= SCAN_IDLE;
                endcase
            end
        end
    end

    keypad_code_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push_req),
        .push_code    (push_code),
        .pop          (fifo_pop),
        .flush        (fifo_flush),
        .clr_overflow (fifo_clr_ovf),
        .head         (fifo_head),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .count        (fifo_count),
        .overflow     (fifo_overflow)
    );

    assign count4      = fifo_count[4] ? 4'hF : fifo_count[3:0];
    assign status_word = {24'b0, count4, |reported, fifo_overflow, fifo_full, ~fifo_empty};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_enable <= 1'b0;
            ctrl_irq_en <= 1'b0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl_enable <= writedata[CTRL_ENABLE];
                ctrl_irq_en <= writedata[CTRL_IRQ_EN];
            end
            irq <= ctrl_irq_en & ~fifo_empty;
            if (bus_rd) begin
                case (address)
                    ADDR_DATA:    readdata <= fifo_empty ? 32'b0 : {27'b0, 1'b1, fifo_head};
                    ADDR_STATUS:  readdata <= status_word;
                    ADDR_CONTROL: readdata <= {30'b0, ctrl_irq_en, ctrl_enable};
                    default:      readdata <= 32'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a key-matrix model drives row_n from col_n, and a
// queue of expected key codes is compared against DATA register reads.
module tb_keypad_scan_ctrl;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [3:0]  col_n;
    logic [3:0]  row_n;

    logic [15:0] keys;
    logic [3:0]  exp_q [$];
    logic [31:0] rd;
    int          n_checks = 0;
    int          n_pass   = 0;

    keypad_scan_ctrl #(
        .SCAN_DIV       (4),
        .DEBOUNCE_SCANS (3),
        .FIFO_DEPTH     (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .col_n      (col_n),
        .row_n      (row_n)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col_n[c]) begin
                for (int r = 0; r < 4; r++) begin
                    if (keys[4*c+r]) row_n[r] = 1'b0;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; read = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic read_data_check(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        logic [3:0]  c;
        bus_read(ADDR_DATA, d);
        if (exp_q.size() == 0) begin
            exp = 32'h0;
        end else begin
            c   = exp_q.pop_front();
            exp = {27'b0, 1'b1, c};
        end
        check_val(tag, d, exp);
    endtask

    task automatic status_check(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(ADDR_STATUS, d);
        check_val(tag, d, exp);
    endtask

    // Returns at the negedge just after COL(0) begins.
    task automatic wait_frame_start();
        logic [3:0] prev;
        bit         seen;
        seen = 1'b0;
        prev = col_n;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (prev == 4'hF && col_n == 4'hE) begin
                seen = 1'b1;
                break;
            end
            prev = col_n;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL frame_timeout: col_n 0x%0h never started a frame", col_n);
        end
    endtask

    task automatic wait_frames(input int n);
        for (int i = 0; i < n; i++) wait_frame_start();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
        address = 2'd0; writedata = 32'h0; keys = 16'h0;
        repeat (3) @(negedge clk);
        check_val("rst_col_n", {28'b0, col_n}, 32'hF);
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;

        // basic press of key 6 (col 1, row 2)
        keys = 16'h0040;
        exp_q.push_back(4'd6);
        bus_write(ADDR_CONTROL, 32'h3);
        repeat (45) @(negedge clk);
        check_val("irq_early", {31'b0, irq}, 32'h0);
        repeat (8) @(negedge clk);
        check_val("irq_rise", {31'b0, irq}, 32'h1);
        read_data_check("data_key6");
        @(negedge clk);
        check_val("irq_fall", {31'b0, irq}, 32'h0);
        read_data_check("data_empty");
        wait_frames(2);
        status_check("held_no_repush", 32'h08);
        keys = 16'h0;
        wait_frames(5);
        status_check("released", 32'h00);

        // bounce: pressed on frames 1,3 then held from frame 5
        for (int f = 0; f < 7; f++) begin
            wait_frame_start();
            keys = (f == 0 || f == 2 || f >= 4) ? 16'h0040 : 16'h0;
            repeat (3) @(negedge clk);
            status_check("bounce_no_push", 32'h00);
        end
        exp_q.push_back(4'd6);
        wait_frame_start();
        repeat (3) @(negedge clk);
        status_check("bounce_push", 32'h19);
        keys = 16'h0;
        read_data_check("bounce_data");
        wait_frames(5);

        // multi-key: keys 0 and 15 together
        wait_frame_start();
        keys = 16'h8001;
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd15);
        wait_frames(5);
        status_check("multi_status", 32'h29);
        read_data_check("multi_first");
        read_data_check("multi_second");
        keys = 16'h0;
        wait_frames(5);
        status_check("multi_release", 32'h00);

        // overflow: five presses into a four-entry FIFO
        for (int k = 1; k <= 5; k++) begin
            wait_frame_start();
            keys = 16'h1 << k;
            if (k <= 4) exp_q.push_back(4'(k));
            wait_frames(4);
            keys = 16'h0;
            wait_frames(4);
        end
        status_check("ovf_status", 32'h47);
        check_val("ovf_irq", {31'b0, irq}, 32'h1);
        read_data_check("ovf_first");
        bus_write(ADDR_CLEAR, 32'h1);
        status_check("ovf_cleared", 32'h31);
        read_data_check("ovf_drain2");
        read_data_check("ovf_drain3");
        read_data_check("ovf_drain4");
        read_data_check("ovf_empty");

        // disable in COL(2), then re-enable
        wait_frame_start();
        keys = 16'h0200;
        exp_q.push_back(4'd9);
        wait_frames(4);
        status_check("dis_pre", 32'h19);
        wait_frame_start();
        repeat (9) @(negedge clk);
        check_val("col2_active", {28'b0, col_n}, 32'hB);
        bus_write(ADDR_CONTROL, 32'h2);
        check_val("dis_col_idle", {28'b0, col_n}, 32'hF);
        status_check("dis_fifo_kept", 32'h11);
        repeat (20) @(negedge clk);
        check_val("dis_stays_idle", {28'b0, col_n}, 32'hF);
        bus_write(ADDR_CONTROL, 32'h3);
        check_val("reen_col0", {28'b0, col_n}, 32'hE);
        wait_frame_start();
        repeat (3) @(negedge clk);
        status_check("reen_no_early_push", 32'h11);
        exp_q.push_back(4'd9);
        wait_frames(2);
        repeat (3) @(negedge clk);
        status_check("reen_push", 32'h29);
        read_data_check("reen_data");

        // asynchronous reset in the middle of a scan
        wait_frame_start();
        repeat (5) @(negedge clk);
        check_val("irq_pre_reset", {31'b0, irq}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        check_val("mid_rst_col_n", {28'b0, col_n}, 32'hF);
        check_val("mid_rst_readdata", readdata, 32'h0);
        check_val("mid_rst_irq", {31'b0, irq}, 32'h0);
        exp_q.delete();
        keys = 16'h0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        status_check("mid_rst_status", 32'h00);
        bus_read(ADDR_CONTROL, rd);
        check_val("mid_rst_control", rd, 32'h0);
        check_val("mid_rst_idle", {28'b0, col_n}, 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
